i2c_mem_slave: RTL and testbench

- I2C target (slave) holding a 128x8 memory.
- Sits on the shared SDA/SCL bus directly downstream of the team's I2C master and consumes the transactions it produces.
- Write: device address, memory pointer, data bytes, with pointer auto-increment.
- Read: streams bytes from the current pointer until the master NACKs.

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_mem_slave_if.sv | 11 +
 rtl/i2c_bus_sync.sv | 47 ++++
 rtl/i2c_mem_slave.sv | 188 ++++++++++++++++++
 tb/tb_i2c_mem_slave.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, ACK/NACK bit levels and the
// default target bus address.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_DEV_ADDR = 4'd1,
    S_ACK_DEV  = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_ACK_MEM  = 4'd4,
    S_WR_DATA  = 4'd5,
    S_ACK_WR   = 4'd6,
    S_RD_DATA  = 4'd7,
    S_MACK     = 4'd8
  } i2c_slave_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [6:0] I2C_DEFAULT_DEV_ADDR = 7'h50;

endpackage

// File: rtl/i2c_mem_slave_if.sv
// Open-drain I2C bus seen by one target.
// Semantics: sda is the resolved line level (wired-AND of every device);
// sda_oe=1 means this target pulls SDA low, 0 means released. SCL is never driven by the target.
interface i2c_mem_slave_if;
  logic scl;
  logic sda;
  logic sda_oe;

  modport slave  (input scl, input sda, output sda_oe);
  modport master (output scl, output sda, input sda_oe);
endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronisers plus one history flop each, giving clean edge strobes
// and START/STOP detection in the clk domain.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o,
  output logic sda_s_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_h_q;
  logic                   sda_h_q;
  logic                   scl_s;
  logic                   sda_s;

  // Idle bus level is high on both lines, so reset everything to 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_h_q    <= 1'b1;
      sda_h_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_h_q    <= scl_s;
      sda_h_q    <= sda_s;
    end
  end

  assign scl_s       = scl_sync_q[SYNC_STAGES-1];
  assign sda_s       = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_o  = scl_s & ~scl_h_q;
  assign scl_fall_o  = ~scl_s & scl_h_q;
  assign start_det_o = scl_s & scl_h_q & sda_h_q & ~sda_s;
  assign stop_det_o  = scl_s & scl_h_q & ~sda_h_q & sda_s;
  assign sda_s_o     = sda_s;

endmodule

// File: rtl/i2c_mem_slave.sv
// I2C target with a byte memory: pointer write, burst write with auto-increment,
// and streaming read until the master NACKs.
module i2c_mem_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = I2C_DEFAULT_DEV_ADDR,
  parameter int         MEM_DEPTH   = 128,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  i2c_mem_slave_if.slave                 bus,
  output logic                           busy,
  output logic                           wr_pulse,
  output logic                           rd_pulse,
  output logic [$clog2(MEM_DEPTH)-1:0]   mem_ptr,
  output logic                           addr_hit,
  output i2c_slave_state_t               state_o
);

  localparam int PTR_W = $clog2(MEM_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (bus.scl),
    .sda_i      (bus.sda),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_det_o(start_det),
    .stop_det_o (stop_det),
    .sda_s_o    (sda_s)
  );

  i2c_slave_state_t state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       sr_q, sr_d;
  logic             rw_q, rw_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             oe_q, oe_d;
  // ACK states: SDA already pulled low. RD_DATA: 8th rise seen. MACK: master ACKed.
  logic             phase_q, phase_d;
  logic [7:0]       rx_byte;
  logic             wr_en;
  logic [7:0]       mem_q [MEM_DEPTH];
  logic [7:0]       rd_buf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      rw_q    <= 1'b0;
      ptr_q   <= '0;
      oe_q    <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      rw_q    <= rw_d;
      ptr_q   <= ptr_d;
      oe_q    <= oe_d;
      phase_q <= phase_d;
    end
  end

  // Memory and read buffer carry no reset; rd_buf tracks the pointer every clk.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[ptr_q] <= rx_byte;
    rd_buf_q <= mem_q[ptr_q];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    rw_d     = rw_q;
    ptr_d    = ptr_q;
    oe_d     = oe_q;
    phase_d  = phase_q;
    wr_en    = 1'b0;
    rd_pulse = 1'b0;
    addr_hit = 1'b0;
    rx_byte  = {sr_q[6:0], sda_s};

    if (stop_det) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      phase_d = 1'b0;
    end else if (start_det) begin
      state_d = S_DEV_ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
      phase_d = 1'b0;
    end else begin
      case (state_q)
        S_DEV_ADDR, S_MEM_ADDR, S_WR_DATA: begin
          if (scl_rise) begin
            sr_d    = rx_byte;
            cnt_d   = cnt_q + 3'd1;
            phase_d = 1'b0;
            if (cnt_q == 3'd7) begin
              if (state_q == S_DEV_ADDR) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  addr_hit = 1'b1;
                  rw_d     = rx_byte[0];
                  state_d  = S_ACK_DEV;
                end else begin
                  state_d = S_IDLE;
                end
              end else if (state_q == S_MEM_ADDR) begin
                ptr_d   = rx_byte[PTR_W-1:0];
                state_d = S_ACK_MEM;
              end else begin
                wr_en   = 1'b1;
                ptr_d   = ptr_q + PTR_ONE;
                state_d = S_ACK_WR;
              end
            end
          end
        end
        S_ACK_DEV, S_ACK_MEM, S_ACK_WR: begin
          if (scl_fall) begin
            if (!phase_q) begin
              oe_d    = 1'b1;
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              cnt_d   = '0;
              oe_d    = 1'b0;
              if (state_q == S_ACK_DEV && rw_q) begin
                state_d  = S_RD_DATA;
                sr_d     = rd_buf_q;
                rd_pulse = 1'b1;
                oe_d     = ~rd_buf_q[7];
              end else if (state_q == S_ACK_DEV) begin
                state_d = S_MEM_ADDR;
              end else begin
                state_d = S_WR_DATA;
              end
            end
          end
        end
        S_RD_DATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) phase_d = 1'b1;
          end else if (scl_fall) begin
            if (phase_q) begin
              phase_d = 1'b0;
              oe_d    = 1'b0;
              ptr_d   = ptr_q + PTR_ONE;
              state_d = S_MACK;
            end else begin
              sr_d = {sr_q[6:0], 1'b0};
              oe_d = ~sr_q[6];
            end
          end
        end
        S_MACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_ACK) phase_d = 1'b1;
            else                  state_d = S_IDLE;
          end else if (scl_fall && phase_q) begin
            phase_d  = 1'b0;
            cnt_d    = '0;
            sr_d     = rd_buf_q;
            rd_pulse = 1'b1;
            oe_d     = ~rd_buf_q[7];
            state_d  = S_RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sda_oe = oe_q;
  assign busy       = (state_q != S_IDLE);
  assign wr_pulse   = wr_en;
  assign mem_ptr    = ptr_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_i2c_mem_slave.sv
// Bench for i2c_mem_slave: bit-banged I2C master, table of write/read-back
// vectors, and directed sequences for wrap, mismatch, early STOP and reset.
module tb_i2c_mem_slave;
  import i2c_pkg::*;

  localparam int Q = 60;

  logic clk, rst;
  logic m_scl, m_sda;
  logic busy, wr_pulse, rd_pulse, addr_hit;
  logic [6:0] mem_ptr;
  i2c_slave_state_t state;

  i2c_mem_slave_if bus();
  assign bus.scl = m_scl;
  assign bus.sda = m_sda & ~bus.sda_oe;

  i2c_mem_slave dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .wr_pulse(wr_pulse),
    .rd_pulse(rd_pulse),
    .mem_ptr (mem_ptr),
    .addr_hit(addr_hit),
    .state_o (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, rd_cnt = 0, hit_cnt = 0, oe_cnt = 0;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (wr_pulse)   wr_cnt++;
    if (rd_pulse)   rd_cnt++;
    if (addr_hit)   hit_cnt++;
    if (bus.sda_oe) oe_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic bit_out(input logic b);
    m_sda = b; #Q; m_scl = 1'b1; #Q; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic bit_in(output logic b);
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; b = bus.sda; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; m_sda = 1'b0; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #Q; m_scl = 1'b1; #Q; m_sda = 1'b1; #Q;
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(v[i]);
    bit_in(ack);
  endtask

  task automatic recv_byte(input logic ack_out, output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      v[i] = b;
    end
    bit_out(ack_out);
  endtask

  task automatic do_write(input logic [7:0] ptr_b, input logic [7:0] d0,
                          input logic [7:0] d1, input int n, output logic nack);
    logic a;
    nack = 1'b0;
    i2c_start();
    send_byte(8'hA0, a); nack |= a;
    send_byte(ptr_b, a); nack |= a;
    if (n > 0) begin send_byte(d0, a); nack |= a; end
    if (n > 1) begin send_byte(d1, a); nack |= a; end
    i2c_stop();
    #50;
  endtask

  // random read: pointer write, repeated START, n bytes (last one NACKed)
  task automatic do_read(input logic [7:0] ptr_b, input int n);
    logic a, nack;
    logic [7:0] v, e;
    nack = 1'b0;
    i2c_start();
    send_byte(8'hA0, a); nack |= a;
    send_byte(ptr_b, a); nack |= a;
    i2c_start();
    send_byte(8'hA1, a); nack |= a;
    check("rd_hdr_acks", nack, 1'b0);
    for (int k = 0; k < n; k++) begin
      recv_byte((k == n - 1) ? I2C_NACK : I2C_ACK, v);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check("rd_data", v, e);
    end
    i2c_stop();
    #50;
  endtask

  typedef struct {
    logic [7:0] ptr_b;
    logic [7:0] data;
    logic [6:0] exp_ptr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic a1, a2, a3, nack, dummy;
    int w0, r0, h0, o0;

    vecs[0] = '{8'h7E, 8'h3C, 7'h7F};
    vecs[1] = '{8'h7F, 8'h5A, 7'h00};
    vecs[2] = '{8'h00, 8'hFF, 7'h01};
    vecs[3] = '{8'h40, 8'h00, 7'h41};
    vecs[4] = '{8'h85, 8'h69, 7'h06};
    vecs[5] = '{8'h2A, 8'h96, 7'h2B};

    rst = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
    #23;
    check("rst_state", state, S_IDLE);
    check("rst_busy", busy, 1'b0);
    check("rst_ptr", mem_ptr, 7'h00);
    check("rst_sda_oe", bus.sda_oe, 1'b0);
    check("rst_pulses", {wr_pulse, rd_pulse, addr_hit}, 3'b000);
    #20 rst = 1'b1;
    #40;

    // basic write
    w0 = wr_cnt; h0 = hit_cnt;
    i2c_start();
    check("busy_after_start", busy, 1'b1);
    send_byte(8'hA0, a1);
    send_byte(8'h10, a2);
    send_byte(8'hA5, a3);
    check("wr_acks", {a1, a2, a3}, 3'b000);
    i2c_stop();
    #50;
    check("wr_pulse_cnt", wr_cnt - w0, 1);
    check("wr_hit_cnt", hit_cnt - h0, 1);
    check("wr_ptr", mem_ptr, 7'h11);
    check("wr_busy_after_stop", busy, 1'b0);

    // random read
    r0 = rd_cnt;
    exp_q.push_back(8'hA5);
    do_read(8'h10, 1);
    check("rr_pulse_cnt", rd_cnt - r0, 1);
    check("rr_ptr", mem_ptr, 7'h11);
    check("rr_busy", busy, 1'b0);

    // wrap burst
    do_write(8'h01, 8'h33, 8'h00, 1, nack);
    check("pre_wr_ack", nack, 1'b0);
    w0 = wr_cnt;
    do_write(8'h7F, 8'h11, 8'h22, 2, nack);
    check("wrap_acks", nack, 1'b0);
    check("wrap_wr_cnt", wr_cnt - w0, 2);
    check("wrap_ptr", mem_ptr, 7'h01);
    r0 = rd_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    do_read(8'h7F, 3);
    check("burst_rd_cnt", rd_cnt - r0, 3);
    check("burst_ptr", mem_ptr, 7'h02);

    // table vectors
    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].ptr_b, vecs[i].data, 8'h00, 1, nack);
      check("vec_wr_ack", nack, 1'b0);
      check("vec_wr_ptr", mem_ptr, vecs[i].exp_ptr);
      exp_q.push_back(vecs[i].data);
      do_read(vecs[i].ptr_b, 1);
      check("vec_rd_ptr", mem_ptr, vecs[i].exp_ptr);
    end

    // address mismatch
    w0 = wr_cnt; h0 = hit_cnt;
    i2c_start();
    send_byte(8'hA2, a1);
    check("mismatch_dev_nack", a1, I2C_NACK);
    send_byte(8'h10, a2);
    check("mismatch_data_nack", a2, I2C_NACK);
    i2c_stop();
    #50;
    check("mismatch_hit", hit_cnt - h0, 0);
    check("mismatch_wr", wr_cnt - w0, 0);
    check("mismatch_ptr", mem_ptr, 7'h2B);
    exp_q.push_back(8'hA5);
    do_read(8'h10, 1);

    // STOP after 4 data bits
    do_write(8'h30, 8'h77, 8'h00, 1, nack);
    check("pstop_pre_ack", nack, 1'b0);
    w0 = wr_cnt;
    i2c_start();
    send_byte(8'hA0, a1);
    send_byte(8'h30, a2);
    bit_out(1'b1); bit_out(1'b1); bit_out(1'b0); bit_out(1'b0);
    i2c_stop();
    #50;
    check("pstop_no_write", wr_cnt - w0, 0);
    check("pstop_state", state, S_IDLE);
    check("pstop_busy", busy, 1'b0);
    check("pstop_ptr", mem_ptr, 7'h30);
    exp_q.push_back(8'h77);
    do_read(8'h30, 1);
    check("pstop_rd_ptr", mem_ptr, 7'h31);

    // reset while driving a 0 data bit
    do_write(8'h20, 8'h0F, 8'h00, 1, nack);
    check("rst_pre_ack", nack, 1'b0);
    i2c_start();
    send_byte(8'hA0, a1);
    send_byte(8'h20, a2);
    i2c_start();
    send_byte(8'hA1, a3);
    check("rst_hdr_acks", {a1, a2, a3}, 3'b000);
    check("rst_rd_state", state, S_RD_DATA);
    check("rst_bit7_drive", bus.sda_oe, 1'b1);
    #7 rst = 1'b0;
    #1;
    check("rst_async_release", bus.sda_oe, 1'b0);
    check("rst_async_sda", bus.sda, 1'b1);
    check("rst_async_ptr", mem_ptr, 7'h00);
    check("rst_async_busy", busy, 1'b0);
    #30 rst = 1'b1;
    o0 = oe_cnt; h0 = hit_cnt;
    for (int i = 0; i < 9; i++) bit_in(dummy);
    check("post_rst_no_drive", oe_cnt - o0, 0);
    check("post_rst_no_hit", hit_cnt - h0, 0);
    check("post_rst_state", state, S_IDLE);
    i2c_stop();
    #50;
    do_write(8'h21, 8'h5A, 8'h00, 1, nack);
    check("post_rst_wr_ack", nack, 1'b0);
    exp_q.push_back(8'h5A);
    do_read(8'h21, 1);
    check("post_rst_ptr", mem_ptr, 7'h22);

    check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
